// File: rtl/path_probe_pkg.sv
// Shared types and constants for the path delay probe: FSM encoding and per-trial overhead.
package path_probe_pkg;

    typedef enum logic [2:0] {
        PROBE_IDLE,
        PROBE_SETTLE,
        PROBE_LAUNCH,
        PROBE_CAPTURE,
        PROBE_SYNC,
        PROBE_CHECK,
        PROBE_DONE
    } probe_state_e;

    // LAUNCH + SYNC + CHECK, on top of the settle and capture windows
    localparam int LATENCY_OVERHEAD = 3;

    function automatic int trial_cycles(input int settle, input int capture);
        return settle + capture + LATENCY_OVERHEAD;
    endfunction

endpackage

// File: rtl/path_delay_probe_if.sv
// Control/status bundle between a run controller plus delay chain (master) and the probe (slave).
interface path_delay_probe_if #(
    parameter int TRIALS_W = 16,
    parameter int ERR_W    = 16
);
    logic                start;
    logic [TRIALS_W-1:0] numTrials;
    logic                pathInput;
    logic                pathResult;
    logic                busy;
    logic                done;
    logic [ERR_W-1:0]    errCount;
    logic                lastSample;

    modport master (
        output start, numTrials, pathResult,
        input  pathInput, busy, done, errCount, lastSample
    );

    modport slave (
        input  start, numTrials, pathResult,
        output pathInput, busy, done, errCount, lastSample
    );
endinterface

// File: rtl/path_capture_sync.sv
// Single capture flop on the chain output followed by one resynchronising stage.
module path_capture_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_cap_en,
    input  logic i_sync_en,
    input  logic i_path_result,
    output logic o_sync
);
    // The only flop sampling the chain; its setup slack is the quantity being measured.
    (* keep = "true", dont_touch = "true" *) logic r_cap;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap  <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            if (i_cap_en)  r_cap  <= i_path_result;
            if (i_sync_en) r_sync <= r_cap;
        end
    end

    assign o_sync = r_sync;
endmodule

// File: rtl/path_delay_probe.sv
// Launches alternating edges into a delay chain, captures a fixed number of edges later,
// and counts late/wrong arrivals over a run of trials.
module path_delay_probe
    import path_probe_pkg::*;
#(
    parameter int CAPTURE_CYCLES = 1,
    parameter int SETTLE_CYCLES  = 4,
    parameter int INVERT         = 0,
    parameter int TRIALS_W       = 16,
    parameter int ERR_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    path_delay_probe_if.slave bus
);
    localparam int   CNT_MAX = (SETTLE_CYCLES > CAPTURE_CYCLES) ? SETTLE_CYCLES : CAPTURE_CYCLES;
    localparam int   CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic P_INV   = (INVERT != 0);

    probe_state_e        r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [TRIALS_W-1:0] r_num, r_trial, w_trial_nxt;
    logic [ERR_W-1:0]    r_err;
    logic                r_path_in, r_busy, r_last;
    logic                w_sync, w_cap_en, w_sync_en, w_launch, w_check, w_done, w_accept;
    logic                w_settle_end, w_capture_end, w_mismatch, w_count;

    assign w_trial_nxt   = r_trial + TRIALS_W'(1);
    assign w_settle_end  = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign w_capture_end = (r_cnt == CNT_W'(CAPTURE_CYCLES - 1));
    assign w_mismatch    = (w_sync != (r_path_in ^ P_INV));

    always_ff @(posedge clk) begin
        if (rst) r_state <= PROBE_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            PROBE_IDLE:    if (bus.start) w_next = (bus.numTrials != '0) ? PROBE_SETTLE : PROBE_DONE;
            PROBE_SETTLE:  if (w_settle_end) w_next = PROBE_LAUNCH;
            PROBE_LAUNCH:  w_next = PROBE_CAPTURE;
            PROBE_CAPTURE: if (w_capture_end) w_next = PROBE_SYNC;
            PROBE_SYNC:    w_next = PROBE_CHECK;
            PROBE_CHECK:   w_next = (w_trial_nxt == r_num) ? PROBE_DONE : PROBE_SETTLE;
            PROBE_DONE:    w_next = PROBE_IDLE;
            default:       w_next = PROBE_IDLE;
        endcase
    end

    always_comb begin
        w_accept  = (r_state == PROBE_IDLE) && bus.start;
        w_launch  = (r_state == PROBE_LAUNCH);
        w_cap_en  = (r_state == PROBE_CAPTURE) && w_capture_end;
        w_sync_en = (r_state == PROBE_SYNC);
        w_check   = (r_state == PROBE_CHECK);
        w_done    = (r_state == PROBE_DONE);
        // Phase counter only runs while dwelling in a timed state.
        w_count   = (w_next == r_state) &&
                    ((r_state == PROBE_SETTLE) || (r_state == PROBE_CAPTURE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_num     <= '0;
            r_trial   <= '0;
            r_err     <= '0;
            r_path_in <= 1'b0;
            r_busy    <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            r_cnt <= w_count ? r_cnt + CNT_W'(1) : '0;
            if (w_accept) begin
                r_num   <= bus.numTrials;
                r_trial <= '0;
                r_err   <= '0;
                r_busy  <= (bus.numTrials != '0);
            end
            if (w_launch) r_path_in <= ~r_path_in;
            if (w_check) begin
                r_last  <= w_sync;
                r_trial <= w_trial_nxt;
                if (w_mismatch && (r_err != '1)) r_err <= r_err + ERR_W'(1);
            end
            if (w_done) r_busy <= 1'b0;
        end
    end

    path_capture_sync u_cap (
        .clk          (clk),
        .rst          (rst),
        .i_cap_en     (w_cap_en),
        .i_sync_en    (w_sync_en),
        .i_path_result(bus.pathResult),
        .o_sync       (w_sync)
    );

    assign bus.pathInput  = r_path_in;
    assign bus.busy       = r_busy;
    assign bus.done       = w_done;
    assign bus.errCount   = r_err;
    assign bus.lastSample = r_last;
endmodule

// File: tb/tb_path_delay_probe.sv
// Three probes (plain, inverting, 3-bit error count) each driving a modelled D-cycle delay chain.
module tb_path_delay_probe;
    localparam int CAP = 1;
    localparam int SET = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    path_delay_probe_if #(.TRIALS_W(16), .ERR_W(16)) if0 ();
    path_delay_probe_if #(.TRIALS_W(16), .ERR_W(16)) if1 ();
    path_delay_probe_if #(.TRIALS_W(16), .ERR_W(3))  if2 ();

    path_delay_probe #(.CAPTURE_CYCLES(CAP), .SETTLE_CYCLES(SET), .INVERT(0), .ERR_W(16))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    path_delay_probe #(.CAPTURE_CYCLES(CAP), .SETTLE_CYCLES(SET), .INVERT(1), .ERR_W(16))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    path_delay_probe #(.CAPTURE_CYCLES(CAP), .SETTLE_CYCLES(SET), .INVERT(0), .ERR_W(3))
        u2 (.clk(clk), .rst(rst), .bus(if2));

    logic        st   [3];
    logic [15:0] nt   [3];
    int          dly  [3];
    logic        minv [3];
    logic [7:0]  sh   [3];
    logic        res  [3];
    logic        pi_o [3], busy_o [3], done_o [3], ls_o [3];
    logic [15:0] err_o [3];

    assign if0.start = st[0];  assign if0.numTrials = nt[0];  assign if0.pathResult = res[0];
    assign if1.start = st[1];  assign if1.numTrials = nt[1];  assign if1.pathResult = res[1];
    assign if2.start = st[2];  assign if2.numTrials = nt[2];  assign if2.pathResult = res[2];
    assign pi_o[0] = if0.pathInput;  assign busy_o[0] = if0.busy;  assign done_o[0] = if0.done;
    assign pi_o[1] = if1.pathInput;  assign busy_o[1] = if1.busy;  assign done_o[1] = if1.done;
    assign pi_o[2] = if2.pathInput;  assign busy_o[2] = if2.busy;  assign done_o[2] = if2.done;
    assign ls_o[0] = if0.lastSample; assign err_o[0] = if0.errCount;
    assign ls_o[1] = if1.lastSample; assign err_o[1] = if1.errCount;
    assign ls_o[2] = if2.lastSample; assign err_o[2] = {13'd0, if2.errCount};

    // Delay chain model: D registered stages (D=0 is purely combinational), optional inversion.
    always_ff @(posedge clk)
        for (int k = 0; k < 3; k++) sh[k] <= {sh[k][6:0], pi_o[k]};

    always_comb
        for (int k = 0; k < 3; k++)
            res[k] = ((dly[k] == 0) ? pi_o[k] : sh[k][(dly[k] == 0) ? 0 : dly[k] - 1]) ^ minv[k];

    typedef struct { int lat; int errs; logic ls; } exp_t;
    exp_t sb[$];

    int   n_cmp = 0;
    int   n_err = 0;
    logic pim [3];
    logic lsm [3];
    int   inv_k [3] = '{0, 1, 0};
    int   emax  [3] = '{65535, 65535, 7};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < 3; k++) begin pim[k] = 1'b0; lsm[k] = 1'b0; end
    endtask

    // One run on probe k: predict, push, pulse start, wait for done, pop and compare.
    task automatic run(input int k, input int n, input bit inj);
        exp_t e;
        int   errs = 0, cycles = 0, dcnt = 0;
        logic old, samp, bseen;
        for (int t = 0; t < n; t++) begin
            old    = pim[k];
            pim[k] = ~pim[k];
            samp   = ((dly[k] < CAP) ? pim[k] : old) ^ minv[k];
            if (samp !== (pim[k] ^ inv_k[k][0]) && errs < emax[k]) errs++;
            lsm[k] = samp;
        end
        e.lat = n * (SET + CAP + 3); e.errs = errs; e.ls = lsm[k];
        sb.push_back(e);
        nt[k] = 16'(n); st[k] = 1'b1;
        @(posedge clk); #1; st[k] = 1'b0;
        bseen = busy_o[k];
        chk($sformatf("busy_after_start_p%0d", k), busy_o[k], n != 0);
        while (!done_o[k] && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
            bseen |= busy_o[k];
            st[k] = (inj && cycles == 20);
        end
        st[k] = 1'b0;
        chk($sformatf("done_seen_p%0d", k), done_o[k], 1);
        e = sb.pop_front();
        chk($sformatf("latency_p%0d_n%0d", k, n), cycles, e.lat);
        chk($sformatf("errCount_p%0d_n%0d", k, n), err_o[k], e.errs);
        chk($sformatf("lastSample_p%0d_n%0d", k, n), ls_o[k], e.ls);
        if (n == 0) chk("busy_never_high_zero_run", bseen, 0);
        @(posedge clk); #1;
        chk($sformatf("done_one_cycle_p%0d", k), done_o[k], 0);
        chk($sformatf("busy_cleared_p%0d", k), busy_o[k], 0);
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; dcnt += done_o[k]; end
        chk($sformatf("no_extra_done_p%0d", k), dcnt, 0);
        chk($sformatf("errCount_holds_p%0d", k), err_o[k], e.errs);
    endtask

    initial begin
        int dcnt;
        logic pi_before;
        for (int k = 0; k < 3; k++) begin st[k] = 1'b0; nt[k] = '0; dly[k] = 0; end
        minv[0] = 1'b0; minv[1] = 1'b1; minv[2] = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_pathInput_p%0d", k), pi_o[k], 0);
            chk($sformatf("rst_busy_p%0d", k), busy_o[k], 0);
            chk($sformatf("rst_done_p%0d", k), done_o[k], 0);
            chk($sformatf("rst_errCount_p%0d", k), err_o[k], 0);
            chk($sformatf("rst_lastSample_p%0d", k), ls_o[k], 0);
        end
        repeat (2) @(posedge clk); #1;

        run(0, 8, 0);                   // fast chain: no errors, 64-cycle run
        dly[0] = 3; run(0, 5, 0);       // chain slower than capture window: every trial late
        run(1, 4, 0);                   // inverting probe with matching inverting chain
        minv[1] = 1'b0; run(1, 4, 0);   // inverting probe with a non-inverting chain
        run(0, 0, 0);                   // zero-trial run
        dly[2] = 3; run(2, 10, 1);      // 3-bit error count saturates; mid-run start ignored

        // Abort in CAPTURE of trial 2 (cycle 14 after the accepting edge).
        pi_before = pim[0];
        nt[0] = 16'd4; st[0] = 1'b1;
        @(posedge clk); #1; st[0] = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk("pre_abort_errCount", err_o[0], 1);
        chk("pre_abort_lastSample", ls_o[0], pi_before);
        chk("pre_abort_pathInput", pi_o[0], pi_before);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_pathInput", pi_o[0], 0);
        chk("abort_busy", busy_o[0], 0);
        chk("abort_done", done_o[0], 0);
        chk("abort_errCount", err_o[0], 0);
        chk("abort_lastSample", ls_o[0], 0);
        rst = 1'b0;
        reset_model();
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; dcnt += done_o[0]; end
        chk("abort_no_done", dcnt, 0);
        dly[0] = 0; run(0, 3, 0);       // fresh run after abort

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
